// File: rtl/frogger_pkg.sv
// Shared playfield geometry, colours and small helpers
// for the frogger datapath blocks.
package frogger_pkg;

   typedef logic [9:0] coord_t;
   typedef logic [7:0] color_t;
   typedef logic [3:0] row_t;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int LANE_H   = 48;

   localparam int FROG_X_L = 304;
   localparam int FROG_X_R = 335;

   localparam int NUM_LANES     = 8;
   localparam int CAR_Y_TOP_OFS = 8;
   localparam int CAR_Y_BOT_OFS = 39;

   localparam color_t COL_CAR_R = 8'b11100000;
   localparam color_t COL_CAR_L = 8'b11111100;
   localparam color_t COL_FROG  = 8'b00011100;

   // y coordinate of a given offset inside a row
   function automatic coord_t lane_y(int lane, int ofs);
      return coord_t'(lane * LANE_H + ofs);
   endfunction

endpackage

// File: rtl/lane_obstacle_engine_if.sv
// Pixel query / frog row bundle between the VGA side,
// the player logic and the obstacle engine.
interface lane_obstacle_engine_if;
   import frogger_pkg::*;

   logic   enable;
   row_t   frog_row;
   coord_t next_x;
   coord_t next_y;
   logic   car_pixel;
   color_t car_color;
   logic   collision;
   logic   hit;
   logic   tick;

   modport master (
      output enable, frog_row, next_x, next_y,
      input  car_pixel, car_color, collision, hit, tick
   );

   modport slave (
      input  enable, frog_row, next_x, next_y,
      output car_pixel, car_color, collision, hit, tick
   );

endinterface

// File: rtl/game_tick_gen.sv
// Game-step strobe: one-cycle tick every TICK_DIV
// enabled cycles; the counter freezes when disabled.
module game_tick_gen #(
   parameter int TICK_DIV = 5000000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic enable_i,
   output logic tick_o
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // next count: wrap after the last value, hold when idle
   always_comb begin
      cnt_d = cnt_q;
      if (enable_i) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      end
   end

   // counter register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/lane_obstacle_engine.sv
// Eight lanes of wrapping cars: per-pixel car/colour
// lookup and frog-row collision, stepped on game ticks.
module lane_obstacle_engine
   import frogger_pkg::*;
#(
   parameter int TICK_DIV = 5000000,
   parameter int STEP_PX  = 32,
   parameter int CAR_W    = 32
) (
   input  logic clock,
   input  logic reset,
   lane_obstacle_engine_if.slave lane_if
);

   logic   tick;
   coord_t car_x_q [NUM_LANES];
   coord_t car_x_d [NUM_LANES];
   logic   in_scr;
   logic   hit_now;
   color_t col_now;
   logic   coll_d;
   logic   car_pixel_q;
   color_t car_color_q;
   logic   collision_q;
   logic   hit_q;

   game_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk_i    (clock),
      .rst_ni   (reset),
      .enable_i (lane_if.enable),
      .tick_o   (tick)
   );

   // one step of a car, wrapping at the screen edges
   function automatic coord_t step_car(coord_t x, logic right);
      coord_t s;
      if (right) begin
         s = x + coord_t'(STEP_PX);
         if (s >= coord_t'(SCREEN_W)) begin
            s = s - coord_t'(SCREEN_W);
         end
      end else if (x == '0) begin
         s = coord_t'(SCREEN_W - STEP_PX);
      end else begin
         s = x - coord_t'(STEP_PX);
      end
      return s;
   endfunction

   // next car positions: odd lanes right, even lanes left
   always_comb begin
      for (int i = 0; i < NUM_LANES; i++) begin
         car_x_d[i] = car_x_q[i];
         if (tick) begin
            car_x_d[i] = step_car(car_x_q[i], (i % 2) == 0);
         end
      end
   end

   // pixel lookup against every lane's car band
   always_comb begin
      hit_now = 1'b0;
      col_now = '0;
      in_scr  = (lane_if.next_x < coord_t'(SCREEN_W))
             && (lane_if.next_y < coord_t'(SCREEN_H));
      for (int i = 0; i < NUM_LANES; i++) begin
         if (in_scr
             && lane_if.next_y >= lane_y(i + 1, CAR_Y_TOP_OFS)
             && lane_if.next_y <= lane_y(i + 1, CAR_Y_BOT_OFS)
             && lane_if.next_x >= car_x_q[i]
             && lane_if.next_x <= car_x_q[i]
                                 + coord_t'(CAR_W - 1)) begin
            hit_now = 1'b1;
            col_now = ((i % 2) == 0) ? COL_CAR_R : COL_CAR_L;
         end
      end
   end

   // car in the frog's lane overlapping the frog column
   always_comb begin
      coll_d = 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (lane_if.frog_row == row_t'(i + 1)
             && car_x_q[i] <= coord_t'(FROG_X_R)
             && car_x_q[i] + coord_t'(CAR_W - 1)
                >= coord_t'(FROG_X_L)) begin
            coll_d = 1'b1;
         end
      end
   end

   // car positions and registered query/collision outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            car_x_q[i] <= coord_t'(64 * i);
         end
         car_pixel_q <= 1'b0;
         car_color_q <= '0;
         collision_q <= 1'b0;
         hit_q       <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_LANES; i++) begin
            car_x_q[i] <= car_x_d[i];
         end
         car_pixel_q <= hit_now;
         car_color_q <= col_now;
         collision_q <= coll_d;
         hit_q       <= coll_d & ~collision_q;
      end
   end

   assign lane_if.car_pixel = car_pixel_q;
   assign lane_if.car_color = car_color_q;
   assign lane_if.collision = collision_q;
   assign lane_if.hit       = hit_q;
   assign lane_if.tick      = tick;

endmodule

// File: tb/tb_lane_obstacle_engine.sv
// Self-checking bench for lane_obstacle_engine
// with TICK_DIV = 4 and a reference lane model.
module tb_lane_obstacle_engine;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [9:0] m_x [8];
   int         m_cnt;
   logic       m_coll;
   logic       m_hit;
   logic [8:0] sbq [$];

   lane_obstacle_engine_if ifc ();

   lane_obstacle_engine #(
      .TICK_DIV (4),
      .STEP_PX  (32),
      .CAR_W    (32)
   ) dut (
      .clock   (clk),
      .reset   (rst_n),
      .lane_if (ifc)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   function automatic logic coll_fn(int row);
      int cx;
      if (row < 1 || row > 8) return 1'b0;
      cx = int'(m_x[row-1]);
      return (cx <= 335) && (cx + 31 >= 304);
   endfunction

   function automatic logic [8:0] exp_pix(int x, int y);
      int r;
      int off;
      int cx;
      if (x >= 640 || y >= 480) return 9'd0;
      r = y / 48;
      if (r < 1 || r > 8) return 9'd0;
      off = y - 48 * r;
      if (off < 8 || off > 39) return 9'd0;
      cx = int'(m_x[r-1]);
      if (x >= cx && x <= cx + 31) begin
         return (r % 2 == 1) ? {1'b1, 8'hE0} : {1'b1, 8'hFC};
      end
      return 9'd0;
   endfunction

   // reference model of counter, lanes and collision
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt  <= 0;
         m_coll <= 1'b0;
         m_hit  <= 1'b0;
         for (int i = 0; i < 8; i++) m_x[i] <= 10'(64 * i);
      end else begin
         m_coll <= coll_fn(int'(ifc.frog_row));
         m_hit  <= coll_fn(int'(ifc.frog_row)) && !m_coll;
         if (ifc.enable) begin
            if (m_cnt == 3) begin
               m_cnt <= 0;
               for (int i = 0; i < 8; i++) begin
                  if (i % 2 == 0)
                     m_x[i] <= 10'((int'(m_x[i]) + 32) % 640);
                  else
                     m_x[i] <= 10'((int'(m_x[i]) + 608) % 640);
               end
            end else begin
               m_cnt <= m_cnt + 1;
            end
         end
      end
   end

   task automatic run_lane_to(int idx, int target);
      bit done = 0;
      ifc.enable = 1'b1;
      for (int n = 0; n < 400; n++) begin
         if (int'(m_x[idx]) == target) begin
            done = 1;
            break;
         end
         @(negedge clk);
      end
      ifc.enable = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL run_lane_to lane %0d got %0d want %0d",
                  idx + 1, m_x[idx], target);
      end
   endtask

   task automatic test_reset();
      bit bad;
      ifc.enable   = 1'b0;
      ifc.frog_row = 4'd0;
      ifc.next_x   = 10'd0;
      ifc.next_y   = 10'd0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({ifc.car_pixel, ifc.car_color, ifc.collision,
           ifc.hit, ifc.tick} !== 12'd0) begin
         errors++;
         $display("FAIL reset_outputs got %h want 0",
                  {ifc.car_pixel, ifc.car_color, ifc.collision,
                   ifc.hit, ifc.tick});
      end
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         checks++;
         if (ifc.tick !== 1'b0) begin
            errors++;
            $display("FAIL idle_tick cycle %0d got %b want 0",
                     c, ifc.tick);
         end
         bad = 0;
         for (int i = 0; i < 8; i++)
            if (dut.car_x_q[i] !== 10'(64 * i)) bad = 1;
         checks++;
         if (bad) begin
            errors++;
            $display("FAIL idle_pos cycle %0d lane1 %0d lane8 %0d",
                     c, dut.car_x_q[0], dut.car_x_q[7]);
         end
         checks++;
         if ({ifc.car_pixel, ifc.car_color, ifc.collision,
              ifc.hit} !== 11'd0) begin
            errors++;
            $display("FAIL idle_outputs cycle %0d got %h want 0",
                     c, {ifc.car_pixel, ifc.car_color,
                         ifc.collision, ifc.hit});
         end
      end
   endtask

   task automatic test_pixel();
      int qx [10] = '{31, 32, 31, 700, 64, 0, 0, 64, 95, 96};
      int qy [10] = '{56, 56, 55, 56, 104, 87, 88, 103, 104, 104};
      logic [8:0] qe [10] = '{9'h1E0, 9'h000, 9'h000, 9'h000,
                              9'h1FC, 9'h1E0, 9'h000, 9'h000,
                              9'h1FC, 9'h000};
      logic [8:0] want;
      logic [8:0] got;
      for (int k = 0; k < 10; k++) begin
         ifc.next_x = 10'(qx[k]);
         ifc.next_y = 10'(qy[k]);
         sbq.push_back(qe[k]);
         @(negedge clk);
         want = sbq.pop_front();
         got  = {ifc.car_pixel, ifc.car_color};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL pixel x=%0d y=%0d got %h want %h",
                     qx[k], qy[k], got, want);
         end
      end
      ifc.next_x = 10'd0;
      ifc.next_y = 10'd0;
   endtask

   task automatic test_motion();
      int ticks = 0;
      int last = -1;
      bit prev = 0;
      bit bad;
      ifc.enable = 1'b1;
      for (int c = 0; c < 84; c++) begin
         checks++;
         if (ifc.tick !== (m_cnt == 3)) begin
            errors++;
            $display("FAIL tick cycle %0d got %b want %b",
                     c, ifc.tick, (m_cnt == 3));
         end
         bad = 0;
         for (int i = 0; i < 8; i++)
            if (dut.car_x_q[i] !== m_x[i]) bad = 1;
         checks++;
         if (bad) begin
            errors++;
            $display("FAIL motion_pos cycle %0d l1 %0d/%0d l2 %0d/%0d",
                     c, dut.car_x_q[0], m_x[0],
                     dut.car_x_q[1], m_x[1]);
         end
         if (prev && ticks == 3) begin
            checks++;
            if (dut.car_x_q[1] !== 10'd608 ||
                dut.car_x_q[0] !== 10'd96) begin
               errors++;
               $display("FAIL wrap_left got l1 %0d l2 %0d want 96 608",
                        dut.car_x_q[0], dut.car_x_q[1]);
            end
         end
         if (prev && ticks == 20) begin
            checks++;
            if (dut.car_x_q[0] !== 10'd0) begin
               errors++;
               $display("FAIL wrap_right got %0d want 0",
                        dut.car_x_q[0]);
            end
         end
         prev = 0;
         if (ifc.tick === 1'b1) begin
            if (last >= 0) begin
               checks++;
               if (c - last != 4) begin
                  errors++;
                  $display("FAIL tick_spacing got %0d want 4",
                           c - last);
               end
            end
            last = c;
            ticks++;
            prev = 1;
         end
         @(negedge clk);
      end
      ifc.enable = 1'b0;
      checks++;
      if (ticks != 21) begin
         errors++;
         $display("FAIL tick_count got %0d want 21", ticks);
      end
   endtask

   task automatic test_collision();
      ifc.frog_row = 4'd0;
      run_lane_to(0, 256);
      ifc.frog_row = 4'd1;
      @(negedge clk);
      checks++;
      if (ifc.collision !== 1'b0 || ifc.hit !== 1'b0) begin
         errors++;
         $display("FAIL coll_256 got %b%b want 00",
                  ifc.collision, ifc.hit);
      end
      ifc.frog_row = 4'd0;
      run_lane_to(0, 288);
      @(negedge clk);
      ifc.frog_row = 4'd1;
      @(negedge clk);
      checks++;
      if (ifc.collision !== 1'b1 || ifc.hit !== 1'b1) begin
         errors++;
         $display("FAIL coll_288 got %b%b want 11",
                  ifc.collision, ifc.hit);
      end
      @(negedge clk);
      checks++;
      if (ifc.collision !== 1'b1 || ifc.hit !== 1'b0) begin
         errors++;
         $display("FAIL coll_288_hold got %b%b want 10",
                  ifc.collision, ifc.hit);
      end
      run_lane_to(0, 320);
      @(negedge clk);
      checks++;
      if (ifc.collision !== 1'b1 || ifc.hit !== 1'b0) begin
         errors++;
         $display("FAIL coll_320 got %b%b want 10",
                  ifc.collision, ifc.hit);
      end
   endtask

   task automatic test_row_gating();
      int rows [3] = '{0, 9, 15};
      for (int k = 0; k < 3; k++) begin
         ifc.frog_row = 4'(rows[k]);
         @(negedge clk);
         checks++;
         if (ifc.collision !== 1'b0 || ifc.hit !== 1'b0) begin
            errors++;
            $display("FAIL gate_row%0d got %b%b want 00",
                     rows[k], ifc.collision, ifc.hit);
         end
      end
      ifc.frog_row = 4'd1;
      @(negedge clk);
      checks++;
      if (ifc.collision !== 1'b1 || ifc.hit !== 1'b1) begin
         errors++;
         $display("FAIL gate_enter got %b%b want 11",
                  ifc.collision, ifc.hit);
      end
      @(negedge clk);
      checks++;
      if (ifc.collision !== 1'b1 || ifc.hit !== 1'b0) begin
         errors++;
         $display("FAIL gate_single_hit got %b%b want 10",
                  ifc.collision, ifc.hit);
      end
      ifc.frog_row = 4'd2;
      @(negedge clk);
      checks++;
      if (ifc.collision !== m_coll || ifc.hit !== m_hit) begin
         errors++;
         $display("FAIL gate_row2 got %b%b want %b%b",
                  ifc.collision, ifc.hit, m_coll, m_hit);
      end
      ifc.frog_row = 4'd0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int r;
      int x;
      int y;
      logic [8:0] want;
      logic [8:0] got;
      ifc.enable = 1'b1;
      for (int c = 0; c < 60; c++) begin
         checks++;
         if (ifc.collision !== m_coll || ifc.hit !== m_hit) begin
            errors++;
            $display("FAIL b2b_coll cycle %0d got %b%b want %b%b",
                     c, ifc.collision, ifc.hit, m_coll, m_hit);
         end
         if (sbq.size() > 0) begin
            want = sbq.pop_front();
            got  = {ifc.car_pixel, ifc.car_color};
            checks++;
            if (got !== want) begin
               errors++;
               $display("FAIL b2b_pixel cycle %0d got %h want %h",
                        c, got, want);
            end
         end
         r = int'($urandom_range(1, 8));
         x = int'(m_x[r-1]) + int'($urandom_range(0, 36)) - 2;
         if (x < 0) x = 0;
         y = 48 * r + int'($urandom_range(4, 43));
         if ($urandom_range(0, 7) == 0) x = int'($urandom_range(600, 900));
         ifc.next_x   = 10'(x);
         ifc.next_y   = 10'(y);
         ifc.frog_row = 4'($urandom_range(0, 10));
         sbq.push_back(exp_pix(x, y));
         @(negedge clk);
      end
      ifc.enable = 1'b0;
      want = sbq.pop_front();
      got  = {ifc.car_pixel, ifc.car_color};
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL b2b_pixel_last got %h want %h", got, want);
      end
      ifc.frog_row = 4'd0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bit bad;
      int first = -1;
      ifc.enable = 1'b1;
      for (int n = 0; n < 8; n++) begin
         if (m_cnt == 2) break;
         @(negedge clk);
      end
      ifc.next_x = m_x[0];
      ifc.next_y = 10'd56;
      @(negedge clk);
      checks++;
      if (ifc.tick !== 1'b1 || ifc.car_pixel !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset got tick %b pix %b want 1 1",
                  ifc.tick, ifc.car_pixel);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({ifc.car_pixel, ifc.car_color, ifc.collision,
           ifc.hit, ifc.tick} !== 12'd0) begin
         errors++;
         $display("FAIL async_reset_out got %h want 0",
                  {ifc.car_pixel, ifc.car_color, ifc.collision,
                   ifc.hit, ifc.tick});
      end
      bad = 0;
      for (int i = 0; i < 8; i++)
         if (dut.car_x_q[i] !== 10'(64 * i)) bad = 1;
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL async_reset_pos l1 %0d l2 %0d want 0 64",
                  dut.car_x_q[0], dut.car_x_q[1]);
      end
      @(negedge clk);
      ifc.next_y = 10'd0;
      rst_n = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (ifc.tick === 1'b1) begin
            first = n;
            break;
         end
      end
      checks++;
      if (first != 3) begin
         errors++;
         $display("FAIL first_tick_after_reset got %0d want 3",
                  first);
      end
      ifc.enable = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_pixel();
      test_motion();
      test_collision();
      test_row_gating();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
